fatori_mon_lsu_err_ctrl: RTL
============================

# fatori_mon_lsu_err_ctrl

Recovery sequencer for the M-of-N hardened load/store unit. It consumes the minority/majority error and scrub flags produced by the LSU voting wrapper and decides when to stall the pipeline. It drains outstanding bus traffic, pulses a recovery request that resynchronises the replicas, and escalates to a sticky fatal state when majority errors keep recurring. It sits between the LSU wrapper and the core controller/halt logic, one instance per hardened LSU.

## Interface
Parameters:
- CNT_W, 16, width of the saturating error counters.
- MAJ_LIMIT, 3, number of recoveries within one burst window that forces FATAL (≥1).
- QUIET_CYCLES, 1024, error-free IDLE cycles that reset the recovery streak (≥1).
- RECOVER_CYCLES, 4, length of the recover_req_o pulse (≥1).
- DRAIN_TIMEOUT, 255, maximum DRAIN cycles waiting for the LSU to go idle (≥1).

Ports:
- clk_i  in  1  clock; all state on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- min_err_i  in  1  voter minority disagreement this cycle.
- maj_err_i  in  1  voter majority (uncorrectable) disagreement this cycle.
- scrub_occurred_i  in  1  register or logic scrub happened this cycle.
- lsu_busy_i  in  1  voted busy_o of the LSU.
- clr_i  in  1  software clear: counters to 0, FATAL → IDLE.
- halt_req_o  out  1  request the core to stop issuing LSU requests.
- recover_req_o  out  1  replica resynchronisation pulse.
- fatal_o  out  1  sticky unrecoverable condition.
- state_o  out  2  FSM state: 0 IDLE, 1 DRAIN, 2 RECOVER, 3 FATAL.
- min_cnt_o  out  CNT_W  saturating count of min_err_i cycles.
- maj_cnt_o  out  CNT_W  saturating count of maj_err_i cycles.
- scrub_cnt_o  out  CNT_W  saturating count of scrub_occurred_i cycles.

## Operation
- Reset: state IDLE. All outputs 0. Streak, quiet, drain and recover counters 0.
- IDLE:
  - If maj_err_i=1, go to DRAIN.
  - Otherwise increment the quiet counter. When it reaches QUIET_CYCLES, clear the streak and the quiet counter.
  - maj_err_i=1 clears the quiet counter.
- DRAIN:
  - halt_req_o=1. The drain counter increments each cycle.
  - If lsu_busy_i=0, go to RECOVER and increment the streak (saturating at MAJ_LIMIT).
  - Else if the drain counter reaches DRAIN_TIMEOUT, go to FATAL.
  - If lsu_busy_i=0 and the timeout occur in the same cycle, RECOVER wins.
- RECOVER:
  - halt_req_o=1 and recover_req_o=1 for RECOVER_CYCLES cycles.
  - A maj_err_i during RECOVER restarts the recover counter; the streak is not incremented.
  - At the end of the pulse: if streak ≥ MAJ_LIMIT, go to FATAL; else go to IDLE with the quiet counter 0.
- FATAL:
  - fatal_o=1 and halt_req_o=1. recover_req_o=0.
  - Leave only on clr_i=1 (to IDLE, streak 0) or on reset.
- clr_i:
  - Always zeroes min/maj/scrub counters. Clear wins over a same-cycle increment.
  - Affects the FSM only in FATAL. Ignored in DRAIN and RECOVER.
- Counters increment by 1 per asserted cycle and saturate at 2^CNT_W−1 (no wrap). They count in every state, including FATAL.
- Simultaneous min_err_i and maj_err_i: both counters increment.

## Timing
- All outputs are registered.
- maj_err_i high at edge k in IDLE gives state_o=1 and halt_req_o=1 after edge k.
- lsu_busy_i low at edge k in DRAIN gives recover_req_o=1 after edge k, held for exactly RECOVER_CYCLES cycles.
- Counter outputs reflect an event one cycle after it is sampled.
- Asynchronous reset mid-DRAIN or mid-RECOVER drops halt_req_o and recover_req_o immediately, without waiting for a clock edge.

## Configuration
- Macro FATORI_MON_ERRCNT_EN, defined: min_cnt_o, maj_cnt_o and scrub_cnt_o are implemented as described.
- Macro FATORI_MON_ERRCNT_EN, undefined: the three counter outputs are tied to 0 and no counter flops exist. The FSM, streak, quiet, drain and recover logic are unchanged.

## Test plan
- Reset, then 3 min_err_i pulses: min_cnt_o=3, state_o stays 0, halt_req_o never rises.
- maj_err_i for 1 cycle with lsu_busy_i=1 for 5 more cycles:
  - halt_req_o rises 1 cycle later.
  - recover_req_o high for 4 cycles after busy drops.
  - Then IDLE; maj_cnt_o=1.
- Three majority episodes within 1024 cycles (MAJ_LIMIT=3): the third RECOVER ends in FATAL with fatal_o=1. clr_i then returns IDLE with all counters 0.
- Two episodes separated by 1100 quiet cycles, repeated 3 times: never FATAL, because the streak resets.
- lsu_busy_i held 1 for 300 cycles after maj_err_i: FATAL after 255 DRAIN cycles; recover_req_o never asserts.
- CNT_W=4, min_err_i held for 20 cycles: min_cnt_o saturates at 15.
- clr_i asserted together with min_err_i: min_cnt_o reads 0.

Source files
------------

// File: rtl/fatori_mon_lsu_err_ctrl.sv
// ============================================================================
// Module   : fatori_mon_lsu_err_ctrl
// Brief    : Recovery sequencer for the M-of-N hardened LSU: drain, replica
//            resync pulse and sticky fatal escalation on recurring majority
//            errors. Optional error counters enabled by FATORI_MON_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fatori_mon_lsu_err_ctrl #(
  parameter int CNT_W          = 16,
  parameter int MAJ_LIMIT      = 3,
  parameter int QUIET_CYCLES   = 1024,
  parameter int RECOVER_CYCLES = 4,
  parameter int DRAIN_TIMEOUT  = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             min_err_i,
  input  logic             maj_err_i,
  input  logic             scrub_occurred_i,
  input  logic             lsu_busy_i,
  input  logic             clr_i,
  output logic             halt_req_o,
  output logic             recover_req_o,
  output logic             fatal_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] min_cnt_o,
  output logic [CNT_W-1:0] maj_cnt_o,
  output logic [CNT_W-1:0] scrub_cnt_o
);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_DRAIN   = 2'd1;
  localparam logic [1:0] c_ST_RECOVER = 2'd2;
  localparam logic [1:0] c_ST_FATAL   = 2'd3;

  localparam int c_QUIET_W  = $clog2(QUIET_CYCLES + 1);
  localparam int c_DRAIN_W  = $clog2(DRAIN_TIMEOUT + 1);
  localparam int c_REC_W    = $clog2(RECOVER_CYCLES + 1);
  localparam int c_STREAK_W = $clog2(MAJ_LIMIT + 1);

  localparam logic [c_QUIET_W-1:0]  c_QUIET_LAST = c_QUIET_W'(QUIET_CYCLES - 1);
  localparam logic [c_DRAIN_W-1:0]  c_DRAIN_LAST = c_DRAIN_W'(DRAIN_TIMEOUT - 1);
  localparam logic [c_REC_W-1:0]    c_REC_LAST   = c_REC_W'(RECOVER_CYCLES - 1);
  localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAJ_LIMIT);

  logic [1:0]            r_state,  w_state_nxt;
  logic [c_STREAK_W-1:0] r_streak, w_streak_nxt;
  logic [c_QUIET_W-1:0]  r_quiet,  w_quiet_nxt;
  logic [c_DRAIN_W-1:0]  r_drain,  w_drain_nxt;
  logic [c_REC_W-1:0]    r_rec,    w_rec_nxt;
  logic                  r_halt, r_recover, r_fatal;

  // Side counters are zero by default so they restart on every state entry.
  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    w_quiet_nxt  = '0;
    w_drain_nxt  = '0;
    w_rec_nxt    = '0;
    case (r_state)
      c_ST_IDLE: begin
        if (maj_err_i) begin
          w_state_nxt = c_ST_DRAIN;
        end else if (r_quiet == c_QUIET_LAST) begin
          w_streak_nxt = '0;
        end else begin
          w_quiet_nxt = r_quiet + 1'b1;
        end
      end
      c_ST_DRAIN: begin
        if (!lsu_busy_i) begin
          w_state_nxt = c_ST_RECOVER;
          if (r_streak != c_STREAK_MAX) w_streak_nxt = r_streak + 1'b1;
        end else if (r_drain == c_DRAIN_LAST) begin
          w_state_nxt = c_ST_FATAL;
        end else begin
          w_drain_nxt = r_drain + 1'b1;
        end
      end
      c_ST_RECOVER: begin
        if (maj_err_i) begin
          w_rec_nxt = '0;
        end else if (r_rec == c_REC_LAST) begin
          w_state_nxt = (r_streak >= c_STREAK_MAX) ? c_ST_FATAL : c_ST_IDLE;
        end else begin
          w_rec_nxt = r_rec + 1'b1;
        end
      end
      c_ST_FATAL: begin
        if (clr_i) begin
          w_state_nxt  = c_ST_IDLE;
          w_streak_nxt = '0;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are flops aligned with state_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= c_ST_IDLE;
      r_streak  <= '0;
      r_quiet   <= '0;
      r_drain   <= '0;
      r_rec     <= '0;
      r_halt    <= 1'b0;
      r_recover <= 1'b0;
      r_fatal   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_streak  <= w_streak_nxt;
      r_quiet   <= w_quiet_nxt;
      r_drain   <= w_drain_nxt;
      r_rec     <= w_rec_nxt;
      r_halt    <= (w_state_nxt != c_ST_IDLE);
      r_recover <= (w_state_nxt == c_ST_RECOVER);
      r_fatal   <= (w_state_nxt == c_ST_FATAL);
    end
  end

  assign state_o       = r_state;
  assign halt_req_o    = r_halt;
  assign recover_req_o = r_recover;
  assign fatal_o       = r_fatal;

`ifdef FATORI_MON_ERRCNT_EN
  logic [2:0]       w_cnt_inc;
  logic [CNT_W-1:0] w_cnt [3];

  assign w_cnt_inc = {scrub_occurred_i, maj_err_i, min_err_i};

  for (genvar gi = 0; gi < 3; gi++) begin : g_errcnt
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt <= '0;
      end else if (clr_i) begin
        r_cnt <= '0;
      end else if (w_cnt_inc[gi] && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
    assign w_cnt[gi] = r_cnt;
  end

  assign min_cnt_o   = w_cnt[0];
  assign maj_cnt_o   = w_cnt[1];
  assign scrub_cnt_o = w_cnt[2];
`else
  logic w_unused_cnt_in;
  assign w_unused_cnt_in = ^{min_err_i, scrub_occurred_i};

  assign min_cnt_o   = '0;
  assign maj_cnt_o   = '0;
  assign scrub_cnt_o = '0;
`endif

endmodule

`default_nettype wire
